// File: rtl/fetch_stepper_pkg.sv
// Shared types and constants for the fetch/step controller.
package fetch_stepper_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // Width of a counter that must be able to hold MEM_LATENCY.
   function automatic int lat_cnt_w(input int mem_latency);
      return (mem_latency < 1) ? 1 : $clog2(mem_latency + 1);
   endfunction
endpackage

// File: rtl/fetch_stepper_debounce.sv
// Button synchronizer + stability filter; pulses step_req on a debounced rising edge.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic step_req
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_1, sync_2, sync_q;
   logic             level, level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         sync_q  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= button;
         sync_2  <= sync_1;
         sync_q  <= sync_2;
         level_q <= level;
         // Any movement of the synchronized level, or agreement with the
         // accepted level, restarts the stability window.
         if (sync_2 != sync_q || sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign step_req = level & ~level_q;
endmodule

// File: rtl/fetch_stepper.sv
// Fetches the instruction at the core PC and gives the core one core_en pulse per step.
module fetch_stepper
   import fetch_stepper_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int MEM_LATENCY     = 1,
   parameter int ADDR_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              button,
   input  logic              run,
   input  logic [31:0]       pc_address,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       instr,
   output logic              core_en,
   output logic              busy,
   output logic              fault,
   output logic [31:0]       step_count
);
   localparam int LAT_W = lat_cnt_w(MEM_LATENCY);

   state_t           state, state_nx;
   logic [LAT_W-1:0] lat_cnt;
   logic             pending, step_req, req, capture, misaligned;
   logic [31:0]      step_cnt;
   logic             unused_pc;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .button   (button),
      .step_req (step_req)
   );

   assign misaligned = (pc_address[1:0] != 2'b00);
   assign unused_pc  = ^pc_address[31:ADDR_W+2];

   always_comb begin
      state_nx = state;
      req      = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            req = run | step_req | pending;
            if (req) state_nx = misaligned ? HALT : FETCH;
         end
         FETCH: begin
            if (lat_cnt == LAT_W'(MEM_LATENCY - 1)) begin
               capture  = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC:    state_nx = IDLE;
         HALT:    state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         pending  <= 1'b0;
         instr    <= NOP_INSTR;
         mem_addr <= '0;
         step_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         state <= state_nx;
         // Single-deep request buffer; extra presses while it is full are lost.
         if (state == IDLE)
            pending <= 1'b0;
         else if (busy && step_req && !run)
            pending <= 1'b1;
         if (state == IDLE && req && !misaligned) begin
            mem_addr <= pc_address[ADDR_W+1:2];
            lat_cnt  <= '0;
         end else if (state == FETCH) begin
            lat_cnt <= lat_cnt + 1'b1;
         end
         if (capture) instr <= mem_rdata;
         if (state == IDLE && req && misaligned) fault <= 1'b1;
         if (state == EXEC) step_cnt <= step_cnt + 32'd1;
      end
   end

   assign core_en    = (state == EXEC) && !rst;
   assign busy       = (state == FETCH) || (state == EXEC);
   assign step_count = step_cnt;
endmodule

// File: tb/tb_fetch_stepper.sv
// Directed bench: instance a (MEM_LATENCY=1) and instance b (MEM_LATENCY=2), both DEBOUNCE_CYCLES=4.
module tb_fetch_stepper;
   import fetch_stepper_pkg::*;

   logic        clk, rst, button, run;
   logic [31:0] pc_a, pc_b, rdata_a, rdata_b;
   logic [7:0]  mem_addr_a, mem_addr_b;
   logic [31:0] instr_a, instr_b, step_count_a, step_count_b;
   logic        core_en_a, core_en_b, busy_a, busy_b, fault_a, fault_b;
   int          total, bad;

   fetch_stepper #(.DEBOUNCE_CYCLES(4), .MEM_LATENCY(1), .ADDR_W(8)) dut_a (
      .clk(clk), .rst(rst), .button(button), .run(run), .pc_address(pc_a),
      .mem_addr(mem_addr_a), .mem_rdata(rdata_a), .instr(instr_a),
      .core_en(core_en_a), .busy(busy_a), .fault(fault_a), .step_count(step_count_a)
   );

   fetch_stepper #(.DEBOUNCE_CYCLES(4), .MEM_LATENCY(2), .ADDR_W(8)) dut_b (
      .clk(clk), .rst(rst), .button(button), .run(run), .pc_address(pc_b),
      .mem_addr(mem_addr_b), .mem_rdata(rdata_b), .instr(instr_b),
      .core_en(core_en_b), .busy(busy_b), .fault(fault_b), .step_count(step_count_b)
   );

   function automatic logic [31:0] rom(input logic [7:0] a);
      return (a == 8'd2) ? 32'h00500093 : {16'hC0DE, 8'h00, a};
   endfunction

   // a: data valid in the same cycle; b: one register stage (latency 2)
   assign rdata_a = rom(mem_addr_a);
   always @(posedge clk) rdata_b <= rom(mem_addr_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] got [12];
      logic [31:0] exp [12];
      run = 1'b0; button = 1'b0; pc_a = 32'h0; pc_b = 32'h0;
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      got[0] = instr_a;                exp[0] = 32'h00000013;
      got[1] = {31'd0, core_en_a};     exp[1] = 32'd0;
      got[2] = {31'd0, busy_a};        exp[2] = 32'd0;
      got[3] = {31'd0, fault_a};       exp[3] = 32'd0;
      got[4] = step_count_a;           exp[4] = 32'd0;
      got[5] = {24'd0, mem_addr_a};    exp[5] = 32'd0;
      got[6] = instr_b;                exp[6] = 32'h00000013;
      got[7] = {31'd0, core_en_b};     exp[7] = 32'd0;
      got[8] = {31'd0, busy_b};        exp[8] = 32'd0;
      got[9] = {31'd0, fault_b};       exp[9] = 32'd0;
      got[10] = step_count_b;          exp[10] = 32'd0;
      got[11] = {24'd0, mem_addr_b};   exp[11] = 32'd0;
      for (int i = 0; i < 12; i++) begin
         total++;
         if (got[i] !== exp[i]) begin
            bad++;
            $display("FAIL reset_%0d got=%h exp=%h", i, got[i], exp[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single_step();
      int req_c, ce_c, n;
      req_c = -100; ce_c = -1; n = 0;
      run = 1'b0; pc_a = 32'h00000008; pc_b = 32'h0;
      do_reset();
      button = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == 14) button = 1'b0;
         if (dut_a.step_req === 1'b1) req_c = i;
         if (core_en_a === 1'b1) begin n++; ce_c = i; end
         @(negedge clk);
      end
      total++;
      if (n != 1) begin bad++; $display("FAIL step_pulses got=%0d exp=1", n); end
      total++;
      if (ce_c - req_c != 2) begin bad++; $display("FAIL step_latency got=%0d exp=2", ce_c - req_c); end
      total++;
      if (mem_addr_a !== 8'd2) begin bad++; $display("FAIL step_mem_addr got=%0d exp=2", mem_addr_a); end
      total++;
      if (instr_a !== 32'h00500093) begin bad++; $display("FAIL step_instr got=%h exp=00500093", instr_a); end
      total++;
      if (step_count_a !== 32'd1) begin bad++; $display("FAIL step_count got=%0d exp=1", step_count_a); end
   endtask

   task automatic test_bounce();
      int n_req, n_ce;
      n_req = 0; n_ce = 0;
      run = 1'b0; pc_a = 32'h0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) button = ~button;
         if (dut_a.step_req === 1'b1) n_req++;
         if (core_en_a === 1'b1) n_ce++;
         @(negedge clk);
      end
      total++;
      if (n_req != 0 || n_ce != 0) begin
         bad++; $display("FAIL bounce_reject got req=%0d ce=%0d exp 0/0", n_req, n_ce);
      end
      button = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == 14) button = 1'b0;
         if (core_en_a === 1'b1) n_ce++;
         @(negedge clk);
      end
      total++;
      if (n_ce != 1) begin bad++; $display("FAIL bounce_hold_step got=%0d exp=1", n_ce); end
      total++;
      if (step_count_a !== 32'd1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", step_count_a); end
   endtask

   task automatic test_free_run();
      logic ce;
      int   k;
      k = 0;
      run = 1'b1; pc_b = 32'h0; pc_a = 32'h0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         ce = core_en_b;
         total++;
         if (ce !== (i % 4 == 3)) begin
            bad++; $display("FAIL run_core_en cycle=%0d got=%b exp=%b", i, ce, (i % 4 == 3));
         end
         if (ce === 1'b1) begin
            total++;
            if (mem_addr_b !== 8'(k) || instr_b !== rom(8'(k))) begin
               bad++;
               $display("FAIL run_fetch k=%0d got addr=%0d instr=%h exp addr=%0d instr=%h",
                        k, mem_addr_b, instr_b, k, rom(8'(k)));
            end
            k++;
         end
         @(posedge clk);
         #1 if (ce === 1'b1) pc_b = pc_b + 32'd4;
         @(negedge clk);
      end
      total++;
      if (step_count_b !== 32'd10) begin bad++; $display("FAIL run_count got=%0d exp=10", step_count_b); end
      run = 1'b0;
   endtask

   task automatic test_pending();
      int n;
      n = 0;
      run = 1'b0; pc_b = 32'h0;
      do_reset();
      for (int i = 0; i < 25; i++) begin
         if (i == 0) force dut_b.step_req = 1'b1;
         if (i == 4) release dut_b.step_req;
         if (core_en_b === 1'b1) n++;
         @(negedge clk);
      end
      total++;
      if (n != 2) begin bad++; $display("FAIL pending_pulses got=%0d exp=2", n); end
      total++;
      if (step_count_b !== 32'd2) begin bad++; $display("FAIL pending_count got=%0d exp=2", step_count_b); end
   endtask

   task automatic test_misaligned();
      int n;
      n = 0;
      run = 1'b1; pc_a = 32'h00000006; pc_b = 32'h0;
      do_reset();
      for (int i = 0; i < 50; i++) begin
         if (core_en_a === 1'b1) n++;
         @(negedge clk);
      end
      total++;
      if (n != 0) begin bad++; $display("FAIL halt_core_en got=%0d exp=0", n); end
      total++;
      if (fault_a !== 1'b1) begin bad++; $display("FAIL halt_fault got=%b exp=1", fault_a); end
      total++;
      if (dut_a.state !== HALT) begin bad++; $display("FAIL halt_state got=%0d exp=%0d", dut_a.state, HALT); end
      total++;
      if (busy_a !== 1'b0 || instr_a !== 32'h00000013) begin
         bad++; $display("FAIL halt_hold got busy=%b instr=%h exp 0/00000013", busy_a, instr_a);
      end
      run = 1'b0;
      do_reset();
      total++;
      if (fault_a !== 1'b0 || dut_a.state !== IDLE) begin
         bad++; $display("FAIL halt_clear got fault=%b state=%0d exp 0/%0d", fault_a, dut_a.state, IDLE);
      end
   endtask

   task automatic test_mid_reset();
      run = 1'b1; pc_a = 32'h0;
      do_reset();
      repeat (2) @(negedge clk);
      total++;
      if (core_en_a !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", core_en_a); end
      rst = 1'b1;
      #1;
      total++;
      if (core_en_a !== 1'b0) begin bad++; $display("FAIL midrst_suppress got=%b exp=0", core_en_a); end
      @(negedge clk) rst = 1'b0;
      total++;
      if (step_count_a !== 32'd0 || busy_a !== 1'b0) begin
         bad++; $display("FAIL midrst_after got cnt=%0d busy=%b exp 0/0", step_count_a, busy_a);
      end
      run = 1'b0;
   endtask

   task automatic test_wrap();
      run = 1'b0; pc_a = 32'h0;
      do_reset();
      force dut_a.step_cnt = 32'hFFFFFFFF;
      @(negedge clk);
      release dut_a.step_cnt;
      @(negedge clk);
      total++;
      if (step_count_a !== 32'hFFFFFFFF) begin
         bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", step_count_a);
      end
      force dut_a.step_req = 1'b1;
      @(negedge clk);
      release dut_a.step_req;
      repeat (5) @(negedge clk);
      total++;
      if (step_count_a !== 32'd0) begin bad++; $display("FAIL wrap_count got=%h exp=00000000", step_count_a); end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; button = 1'b0; run = 1'b0; pc_a = 32'h0; pc_b = 32'h0;
      test_reset();
      test_single_step();
      test_bounce();
      test_free_run();
      test_pending();
      test_misaligned();
      test_mid_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
